muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 137 +++++++++++++
 tb/tb_muldiv_unit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO result registers (MIPS style).
// One bit per cycle: shift-add multiply, restoring divide on magnitudes, sign fix-up at the end.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   p;        // {remainder/partial-product, quotient/multiplier}
  logic [WIDTH-1:0]     opnd;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     a_q;      // original dividend, returned in HI on divide-by-zero
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 b_zero;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       add_sum;
  logic [WIDTH+1:0]     sub_diff;
  logic [2*WIDTH-1:0]   p_next;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quot, rem;
  logic [WIDTH-1:0]     res_hi, res_lo;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    a_neg    = ~op[0] & a[WIDTH-1];
    b_neg    = ~op[0] & b[WIDTH-1];
    a_mag    = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag    = b_neg ? (~b + WIDTH'(1)) : b;

    add_sum  = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? opnd : '0)};
    sub_diff = {1'b0, p[2*WIDTH-1:WIDTH-1]} - {2'b00, opnd};
    p_next   = {add_sum, p[WIDTH-1:1]};
    if (is_div) begin
      // Borrow out of the trial subtraction means the shifted remainder is below the divisor.
      if (sub_diff[WIDTH+1]) p_next = {p[2*WIDTH-2:0], 1'b0};
      else                   p_next = {sub_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
    end

    prod   = neg_q ? (~p + (2*WIDTH)'(1)) : p;
    quot   = neg_q ? (~p[WIDTH-1:0] + WIDTH'(1)) : p[WIDTH-1:0];
    rem    = neg_r ? (~p[2*WIDTH-1:WIDTH] + WIDTH'(1)) : p[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (is_div) begin
      res_hi = b_zero ? a_q : rem;
      res_lo = b_zero ? '1  : quot;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; the datapath registers are
  // reset too so the whole unit comes out of reset in a known state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      p      <= '0;
      opnd   <= '0;
      a_q    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      dbz    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start && !flush) begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            b_zero <= (b == '0);
            a_q    <= a;
            opnd   <= op[1] ? b_mag : a_mag;
            p      <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            p   <= p_next;
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            dbz  <= is_div & b_zero;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32; outputs sampled on the falling edge.
module tb_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, dbz;
  logic [W-1:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int done_cnt;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the following rising edge is the accepting edge.
  task automatic launch(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic wr);
    op = o; a = x; b = y; start = 1'b1;
    hi_we = wr; lo_we = wr; wdata = 32'h0000_0077;
    @(posedge clk);
    #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
  endtask

  // Cycle n is the n-th falling edge after acceptance; returns the cycle where done is seen.
  task automatic wait_done(input string tag, output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
      if (l == 1) check({tag, " busy@1"}, 64'(busy), 64'd1);
    end while (!done && l < 100);
    check({tag, " latency"}, 64'(l), 64'd34);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el,
                           input logic ez);
    check({tag, " hi"},  64'(hi),  64'(eh));
    check({tag, " lo"},  64'(lo),  64'(el));
    check({tag, " dbz"}, 64'(dbz), 64'(ez));
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;

    // Reset state
    #3;
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst hi",   64'(hi),   64'd0);
    check("rst lo",   64'(lo),   64'd0);
    check("rst dbz",  64'(dbz),  64'd0);

    // First start on the first rising edge after release
    @(negedge clk);
    rst = 1'b1;
    launch(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b0);
    wait_done("mult -3*7", lat);
    check_res("mult -3*7", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(negedge clk);
    check("done pulse", 64'(done), 64'd0);
    check("busy after", 64'(busy), 64'd0);

    // Remaining ops launched back-to-back in the done cycle
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("multu max", lat);
    check_res("multu max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

    launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done("mult -1*-1", lat);
    check_res("mult -1*-1", 32'h0000_0000, 32'h0000_0001, 1'b0);

    launch(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    wait_done("div -7/2", lat);
    check_res("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);

    launch(2'b11, 32'h0000_0064, 32'h0000_0000, 1'b0);
    wait_done("divu 100/0", lat);
    check_res("divu 100/0", 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);

    launch(2'b10, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0);
    wait_done("div -16/0", lat);
    check_res("div -16/0", 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);

    launch(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_done("div ovf", lat);
    check_res("div ovf", 32'h0000_0000, 32'h8000_0000, 1'b0);

    launch(2'b11, 32'd100, 32'd7, 1'b0);
    wait_done("divu 100/7", lat);
    check_res("divu 100/7", 32'd2, 32'd14, 1'b0);

    // Direct write together with start: write lands, commit overwrites later
    launch(2'b01, 32'd2, 32'd3, 1'b1);
    @(negedge clk);
    check("we+start hi", 64'(hi), 64'h77);
    check("we+start lo", 64'(lo), 64'h77);
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("we+start latency", 64'(lat), 64'd34);
    check_res("we+start", 32'd0, 32'd6, 1'b0);

    // Preload, then flush mid-operation
    @(negedge clk);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h55;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("preload hi", 64'(hi), 64'h55);
    check("preload lo", 64'(lo), 64'h55);
    launch(2'b01, 32'd3, 32'd5, 1'b0);
    done_cnt = 0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
      if (c == 5) begin
        start = 1'b1; hi_we = 1'b1; wdata = 32'hAA; op = 2'b10; a = 32'd9; b = 32'd0;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      if (c == 6) check("busy ignore hi_we", 64'(hi), 64'h55);
    end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 64'(busy), 64'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("flush no done", 64'(done_cnt), 64'd0);
    check_res("flush keep", 32'h55, 32'h55, 1'b0);

    // Reset in the middle of a divide
    launch(2'b10, 32'd100, 32'd7, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst done", 64'(done), 64'd0);
    check_res("midrst", 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst no done", 64'(done_cnt), 64'd0);
    launch(2'b01, 32'd3, 32'd4, 1'b0);
    wait_done("multu 3*4", lat);
    check_res("multu 3*4", 32'd0, 32'h0000_000C, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
